// File: rtl/serialize_arbiter.sv
// Round-robin arbiter sharing one DIN->DOUT serializer among NUM_CH channels.
// Optional dout_last output enabled by SERIALIZE_ARBITER_LAST_EN.
module serialize_arbiter #(
  parameter int NUM_CH = 2,
  parameter int DIN    = 16,
  parameter int DOUT   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*DIN-1:0]       din_data,
  input  logic [NUM_CH-1:0]           din_valid,
  output logic [NUM_CH-1:0]           din_ready,
  output logic [DOUT-1:0]             dout_data,
  output logic [$clog2(NUM_CH)-1:0]   dout_id,
  output logic                        dout_valid,
`ifdef SERIALIZE_ARBITER_LAST_EN
  output logic                        dout_last,
`endif
  input  logic                        dout_ready
);

  localparam int RATIO = DIN / DOUT;
  localparam int CW    = $clog2(RATIO);
  localparam int IW    = $clog2(NUM_CH);

  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(NUM_CH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            found;
  logic [IW-1:0]   winner;
  logic            xfer;
  logic            last_beat;
  int              base;

  // Round-robin search of din_valid starting at rr_ptr
  always_comb begin : arb_scan
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!found && din_valid[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  // Chunk mux; outputs stay zero outside BUSY
  always_comb begin
    dout_valid = 1'b0;
    dout_data  = '0;
    dout_id    = '0;
    base       = 0;
    if (state_q == BUSY) begin
      dout_valid = din_valid[grant_q];
      base       = int'(grant_q) * DIN + int'(count_q) * DOUT;
      dout_data  = din_data[base +: DOUT];
      dout_id    = grant_q;
    end
  end

  assign xfer      = dout_valid & dout_ready;
  assign last_beat = (count_q == CNT_LAST);

  // Word-consumed pulse on the final chunk's transfer
  always_comb begin
    din_ready = '0;
    if (state_q == BUSY && xfer && last_beat) begin
      din_ready[grant_q] = 1'b1;
    end
  end

`ifdef SERIALIZE_ARBITER_LAST_EN
  assign dout_last = (state_q == BUSY) & dout_valid & last_beat;
`endif

  // Next-state: grant in IDLE, step chunks in BUSY, release on last
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = winner;
          count_d = '0;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (last_beat) begin
            count_d  = '0;
            state_d  = IDLE;
            rr_ptr_d = (grant_q == ID_LAST) ? '0 : grant_q + IW'(1);
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_serialize_arbiter.sv
// Testbench for serialize_arbiter: directed vector table, async reset
// sequence and randomized traffic against a word-level reference model.
module tb_serialize_arbiter;

  localparam int N     = 3;
  localparam int DIN   = 16;
  localparam int DOUT  = 8;
  localparam int RATIO = DIN / DOUT;

  logic              clk;
  logic              rst;
  logic [N*DIN-1:0]  din_data;
  logic [N-1:0]      din_valid;
  logic [N-1:0]      din_ready;
  logic [DOUT-1:0]   dout_data;
  logic [1:0]        dout_id;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  int total = 0;
  int bad   = 0;

  serialize_arbiter #(.NUM_CH(N), .DIN(DIN), .DOUT(DOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_data   (din_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_data  (dout_data),
    .dout_id    (dout_id),
    .dout_valid (dout_valid),
`ifdef SERIALIZE_ARBITER_LAST_EN
    .dout_last  (dout_last),
`endif
    .dout_ready (dout_ready)
  );

`ifndef SERIALIZE_ARBITER_LAST_EN
  assign dout_last = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [15:0] d0, d1, d2;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  eid;
    logic [2:0]  edr;
    logic        elast;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [2:0] v, logic [15:0] a, logic [15:0] b,
                              logic [15:0] c, logic r, logic ev,
                              logic [7:0] ed, logic [1:0] eid,
                              logic [2:0] edr, logic el);
    vec_t t;
    t.valid = v; t.d0 = a; t.d1 = b; t.d2 = c; t.rdy = r;
    t.ev = ev; t.ed = ed; t.eid = eid; t.edr = edr; t.elast = el;
    return t;
  endfunction

  task automatic drive(vec_t t);
    din_valid  = t.valid;
    din_data   = {t.d2, t.d1, t.d0};
    dout_ready = t.rdy;
  endtask

  task automatic check_outs(string nm, vec_t t);
    chk({nm, ".valid"}, 32'(dout_valid), 32'(t.ev));
    chk({nm, ".data"},  32'(dout_data),  32'(t.ed));
    chk({nm, ".id"},    32'(dout_id),    32'(t.eid));
    chk({nm, ".ready"}, 32'(din_ready),  32'(t.edr));
`ifdef SERIALIZE_ARBITER_LAST_EN
    chk({nm, ".last"},  32'(dout_last),  32'(t.elast));
`endif
  endtask

  task automatic apply(string nm, vec_t t);
    drive(t);
    @(negedge clk);
    check_outs(nm, t);
    @(posedge clk);
    #1;
  endtask

  // reference model state (word-level)
  int          m_busy, m_grant, m_cnt, m_ptr;
  logic [15:0] word [N];
  bit          pend [N];

  initial begin
    vec_t t;
    logic [N-1:0] vin;
    logic         rdy;
    logic         ev, elast;
    logic [7:0]   ed;
    logic [1:0]   eid;
    logic [2:0]   edr;

    // directed table, applied from reset with rr_ptr=0
    tbl.push_back(mk(3'b001, 16'hA1B2, 0, 0, 1, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(3'b001, 16'hA1B2, 0, 0, 1, 1, 8'hB2, 0, 3'b000, 0));
    tbl.push_back(mk(3'b001, 16'hA1B2, 0, 0, 1, 1, 8'hA1, 0, 3'b001, 1));
    tbl.push_back(mk(3'b000, 16'hA1B2, 0, 0, 1, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(3'b010, 0, 16'hC3D4, 0, 1, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(3'b010, 0, 16'hC3D4, 0, 1, 1, 8'hD4, 1, 3'b000, 0));
    tbl.push_back(mk(3'b010, 0, 16'hC3D4, 0, 0, 1, 8'hC3, 1, 3'b000, 1));
    tbl.push_back(mk(3'b010, 0, 16'hC3D4, 0, 0, 1, 8'hC3, 1, 3'b000, 1));
    tbl.push_back(mk(3'b010, 0, 16'hC3D4, 0, 0, 1, 8'hC3, 1, 3'b000, 1));
    tbl.push_back(mk(3'b010, 0, 16'hC3D4, 0, 1, 1, 8'hC3, 1, 3'b010, 1));
    tbl.push_back(mk(3'b000, 0, 16'hC3D4, 0, 1, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(3'b100, 0, 0, 16'h5A6B, 1, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(3'b100, 0, 0, 16'h5A6B, 1, 1, 8'h6B, 2, 3'b000, 0));
    tbl.push_back(mk(3'b000, 0, 0, 16'h5A6B, 1, 0, 8'h5A, 2, 3'b000, 0));
    tbl.push_back(mk(3'b100, 0, 0, 16'h5A6B, 1, 1, 8'h5A, 2, 3'b100, 1));
    tbl.push_back(mk(3'b000, 0, 0, 16'h5A6B, 1, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(3'b001, 16'h1234, 0, 16'h5678, 1, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(3'b001, 16'h1234, 0, 16'h5678, 1, 1, 8'h34, 0, 3'b000, 0));
    tbl.push_back(mk(3'b101, 16'h1234, 0, 16'h5678, 1, 1, 8'h12, 0, 3'b001, 1));
    tbl.push_back(mk(3'b101, 16'h1234, 0, 16'h5678, 1, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(3'b101, 16'h1234, 0, 16'h5678, 1, 1, 8'h78, 2, 3'b000, 0));
    tbl.push_back(mk(3'b101, 16'h1234, 0, 16'h5678, 1, 1, 8'h56, 2, 3'b100, 1));
    tbl.push_back(mk(3'b101, 16'h1234, 0, 16'h5678, 1, 0, 8'h00, 0, 3'b000, 0));
    tbl.push_back(mk(3'b101, 16'h1234, 0, 16'h5678, 1, 1, 8'h34, 0, 3'b000, 0));
    tbl.push_back(mk(3'b101, 16'h1234, 0, 16'h5678, 1, 1, 8'h12, 0, 3'b001, 1));
    tbl.push_back(mk(3'b000, 16'h1234, 0, 16'h5678, 1, 0, 8'h00, 0, 3'b000, 0));

    // reset with requests pending: outputs must stay quiet
    rst = 1'b1;
    drive(mk(3'b111, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 3'b000, 0));
    drive(mk(3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // async reset mid-word (rr_ptr=1 now, ch0 alone still wins)
    apply("ar_idle", mk(3'b001, 16'hA1B2, 0, 0, 1, 0, 8'h00, 0, 3'b000, 0));
    apply("ar_c0",   mk(3'b001, 16'hA1B2, 0, 0, 1, 1, 8'hB2, 0, 3'b000, 0));
    #1;
    chk("ar_pre.valid", 32'(dout_valid), 32'd1);
    chk("ar_pre.ready", 32'(din_ready), 32'b001);
    rst = 1'b1;
    #1;
    chk("ar_now.valid", 32'(dout_valid), 32'd0);
    chk("ar_now.ready", 32'(din_ready), 32'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply("ar_rel",  mk(3'b001, 16'hA1B2, 0, 0, 1, 0, 8'h00, 0, 3'b000, 0));
    apply("ar_c0b",  mk(3'b001, 16'hA1B2, 0, 0, 1, 1, 8'hB2, 0, 3'b000, 0));
    apply("ar_c1b",  mk(3'b001, 16'hA1B2, 0, 0, 1, 1, 8'hA1, 0, 3'b001, 1));

    // randomized traffic vs model; reset first for a known pointer
    rst = 1'b1;
    din_valid = '0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_busy = 0; m_grant = 0; m_cnt = 0; m_ptr = 0;
    for (int c = 0; c < N; c++) begin
      pend[c] = 1'b0;
      word[c] = '0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!pend[c] && ($urandom_range(0, 2) == 0)) begin
          pend[c] = 1'b1;
          word[c] = 16'($urandom);
        end
        vin[c] = pend[c] && ($urandom_range(0, 7) != 0);
      end
      rdy = ($urandom_range(0, 3) != 0);
      din_valid  = vin;
      din_data   = {word[2], word[1], word[0]};
      dout_ready = rdy;
      @(negedge clk);
      ev = 0; ed = 0; eid = 0; edr = 0; elast = 0;
      if (m_busy != 0) begin
        ev    = vin[m_grant];
        ed    = 8'(word[m_grant] >> (m_cnt * DOUT));
        eid   = 2'(m_grant);
        elast = ev && (m_cnt == RATIO - 1);
        if (elast && rdy) edr[m_grant] = 1'b1;
      end
      check_outs($sformatf("rnd%0d", cyc),
                 mk(0, 0, 0, 0, 0, ev, ed, eid, edr, elast));
      if (m_busy == 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_busy == 0 && vin[(m_ptr + k) % N]) begin
            m_busy  = 1;
            m_grant = (m_ptr + k) % N;
            m_cnt   = 0;
          end
        end
      end else if (ev && rdy) begin
        if (m_cnt == RATIO - 1) begin
          m_busy = 0;
          m_cnt  = 0;
          m_ptr  = (m_grant + 1) % N;
          pend[m_grant] = 1'b0;
        end else begin
          m_cnt++;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
